// File: rtl/scope_trace_writer.sv
// Writes one oscilloscope column per accepted sample: V_RES erase writes, then span+1 trace writes, then one advance cycle.
// Sample ready is held low for the whole column, and it stays low while i_run=0 or i_restart=1.
module scope_trace_writer #(
   parameter int H_RES    = 640,
   parameter int V_RES    = 480,
   parameter int ADDR_W   = 19,
   parameter int SAMPLE_W = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_run,
   input  logic                i_restart,
   input  logic                i_sample_valid,
   output logic                o_sample_ready,
   input  logic [SAMPLE_W-1:0] i_sample,
   output logic                o_wr_en,
   output logic [ADDR_W:0]     o_wr_addr,
   output logic                o_wr_data,
   output logic [9:0]          o_col,
   output logic                o_busy,
   output logic                o_frame_done
);

   typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_ADVANCE} state_t;

   localparam logic [9:0] ROW_LAST = 10'(V_RES - 1);
   localparam logic [9:0] COL_LAST = 10'(H_RES - 1);

   state_t     state, state_nxt;
   logic [9:0] row;
   logic [9:0] y_new, y_prev;
   logic [9:0] y_lo, y_hi;
   logic       first_col;
   logic       hs;

   // Full-width product so the largest sample never wraps before scaling.
   function automatic logic [9:0] row_of(input logic [SAMPLE_W-1:0] s);
      logic [SAMPLE_W+9:0] prod;
      prod = (SAMPLE_W+10)'(s) * (SAMPLE_W+10)'(V_RES);
      return ROW_LAST - 10'(prod >> SAMPLE_W);
   endfunction

   assign hs = o_sample_ready & i_sample_valid;

   always_comb begin
      y_lo = y_new;
      y_hi = y_new;
      if (!first_col) begin
         y_lo = (y_prev < y_new) ? y_prev : y_new;
         y_hi = (y_prev < y_new) ? y_new  : y_prev;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (hs) state_nxt = S_ERASE;
         S_ERASE:   if (row == ROW_LAST) state_nxt = S_DRAW;
         S_DRAW:    if (row == y_hi) state_nxt = S_ADVANCE;
         S_ADVANCE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_sample_ready = 1'b0;
      o_busy         = 1'b0;
      o_wr_en        = 1'b0;
      o_wr_data      = 1'b0;
      o_frame_done   = 1'b0;
      o_wr_addr      = (ADDR_W+1)'(row) * (ADDR_W+1)'(H_RES) + (ADDR_W+1)'(o_col);
      case (state)
         S_IDLE:    o_sample_ready = i_rst_n & i_run & ~i_restart;
         S_ERASE:   begin o_busy = 1'b1; o_wr_en = 1'b1; end
         S_DRAW:    begin o_busy = 1'b1; o_wr_en = 1'b1; o_wr_data = 1'b1; end
         S_ADVANCE: begin o_busy = 1'b1; o_frame_done = (o_col == COL_LAST); end
         default:   o_busy = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         row       <= '0;
         y_new     <= '0;
         y_prev    <= '0;
         first_col <= 1'b1;
         o_col     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_restart) begin
                  o_col     <= '0;
                  first_col <= 1'b1;
               end else if (hs) begin
                  y_new <= row_of(i_sample);
                  row   <= '0;
               end
            end
            S_ERASE: row <= (row == ROW_LAST) ? y_lo : row + 10'd1;
            S_DRAW:  row <= row + 10'd1;
            S_ADVANCE: begin
               // y_prev survives the wrap so the trace stays continuous across frames.
               y_prev    <= y_new;
               first_col <= 1'b0;
               o_col     <= (o_col == COL_LAST) ? '0 : o_col + 10'd1;
            end
            default: row <= row;
         endcase
      end
   end

endmodule
